apu_out_writeback: RTL and testbench
====================================

# apu_out_writeback

Write-back stage of the APU datapath: accepts 64-bit result words from the compute array over a valid/ready stream, buffers them in a small FIFO, and writes them to one of the two activation SRAMs (A or B) at consecutive addresses. The SRAMs written here are the ones the input buffer reads from on the next layer. The drive follows the same active-low nWe/nCe convention. One burst per iStart; oDone pulses when the last word has been written.

## Interface
- P_BINDWIDTH, 64, data word width
- P_ADDR_W, 10, SRAM address width (1024 words)
- P_FIFO_DEPTH, 4, internal FIFO depth (power of two)

- clk  in  1  clock
- nRst  in  1  reset, asynchronous, active-low
- iStart  in  1  burst start pulse; sampled only in IDLE
- iAbort  in  1  synchronous abort; flushes FIFO and returns to IDLE, no oDone
- iBaseAddr  in  P_ADDR_W  first write address, latched on iStart
- iWordCount  in  P_ADDR_W+1  words in burst, 0..1024, latched on iStart
- iDstSelect  in  1  0 = SRAM A, 1 = SRAM B, latched on iStart
- iValid  in  1  result word valid
- iData  in  P_BINDWIDTH  result word
- oReady  out  1  word accepted when iValid && oReady
- iStall  in  1  SRAM port busy; no pop/write this cycle
- oWeA  out  1  SRAM A write enable, active-low
- oWeB  out  1  SRAM B write enable, active-low
- oCe  out  1  chip enable, active-low, low exactly when a write is issued
- oAddr  out  P_ADDR_W  write address
- oWriteData  out  P_BINDWIDTH  write data
- oBusy  out  1  high in RUN and DRAIN
- oDone  out  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, RUN, DRAIN, DONE (enum in package).
- IDLE: oReady=0; iValid ignored. iStart latches base/count/select; count==0 → DONE, else → RUN. iStart ignored in all other states.
- RUN: oReady = !fifo_full && (acc_cnt < count); fifo_full is registered state, no same-cycle pop bypass. Each handshake pushes iData, acc_cnt++. When acc_cnt reaches count → DRAIN.
- Write side (RUN and DRAIN): if FIFO non-empty and !iStall, pop; next cycle drive oCe=0, the selected oWe*=0 (other stays 1), oAddr = (base + wr_cnt) mod 2^P_ADDR_W (wrap 1023→0), oWriteData = popped word; wr_cnt++. Otherwise oCe=1, oWeA=oWeB=1; oAddr/oWriteData hold last values.
- DRAIN: oReady=0; when wr_cnt == count and the last write has been driven → DONE.
- DONE: oDone=1 for one cycle → IDLE. Counters cleared on IDLE entry.
- iAbort (any state but IDLE): FIFO emptied, counters cleared, write outputs deasserted next cycle, → IDLE; a write driven in the abort cycle completes normally. iAbort wins over simultaneous iStart/push/pop.
- Simultaneous push and pop in one cycle allowed; occupancy unchanged.

## Timing
- Reset values: oReady=0, oWeA=1, oWeB=1, oCe=1, oAddr=0, oWriteData=0, oBusy=0, oDone=0; FSM IDLE, FIFO empty.
- iStart in cycle N → oBusy and oReady (if count>0) high in cycle N+1.
- Word accepted at cycle N appears on SRAM write pins at earliest cycle N+2 (push N, pop N+1, registered write N+2).
- iStall in cycle M suppresses the pop in M; it does not cancel a write already driven in M.
- Last write in cycle L → oDone high in cycle L+1, oBusy low in L+1, IDLE in L+2.
- count==0: oDone pulses in cycle N+1 after iStart, no write issued.
- Sustained throughput with iValid=1, iStall=0: one word/cycle.

## Structure
- Package apu_wb_pkg: state enum, P_ADDR_W/P_BINDWIDTH defaults, FIFO pointer width localparam.
- Sub-module wb_fifo: synchronous FIFO (push, pop, full, empty, flush), depth P_FIFO_DEPTH, registered full/empty.
- Top: FSM, acc/wr counters, address adder with wrap, registered SRAM write outputs.

## Test plan
- Base=0x010, count=4, dst=A, iValid always 1 → oWeA low at addresses 0x010..0x013 on four consecutive cycles, oWeB stays 1, oDone pulse one cycle after last write.
- Base=0x3FE, count=4, dst=B → writes to 0x3FE, 0x3FF, 0x000, 0x001 on oWeB.
- count=8, iStall high for 6 cycles mid-burst → oReady drops after 4 buffered words, no write during stall, all 8 data in order, no loss/duplication.
- count=0 → no oCe assertion, oDone one cycle after iStart; second iStart during a burst ignored.
- iAbort after 3 of 10 words → FIFO flushed, outputs idle next cycle, oDone never pulses, new burst afterwards starts from fresh base.
- Assert nRst mid-burst → all outputs at reset values immediately, no further writes after release.

Source files
------------

// File: rtl/apu_wb_pkg.sv
// apu_out_writeback shared types and defaults.
// FSM state encoding and datapath sizing.
package apu_wb_pkg;

  localparam int WB_BINDWIDTH  = 64;
  localparam int WB_ADDR_W     = 10;
  localparam int WB_FIFO_DEPTH = 4;
  localparam int WB_PTR_W      = $clog2(WB_FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } wb_state_e;

endpackage

// File: rtl/apu_out_writeback_fifo.sv
// Small synchronous FIFO between result stream and SRAM port.
// Full/empty are registered; flush empties it in one cycle.
module wb_fifo #(
  parameter int P_WIDTH = 64,
  parameter int P_DEPTH = 4
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [P_WIDTH-1:0] data_i,
  output logic [P_WIDTH-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int PTR_W = $clog2(P_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(P_DEPTH);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W:0]     cnt_q;
  logic [PTR_W:0]     cnt_d;
  logic               full_q;
  logic               empty_q;
  logic               do_push;
  logic               do_pop;

  assign do_push = push_i && !full_q && !flush_i;
  assign do_pop  = pop_i && !empty_q && !flush_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Occupancy next-state; push+pop together leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)
      cnt_d = '0;
    else if (do_push && !do_pop)
      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push)
      cnt_d = cnt_q - 1'b1;
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/apu_out_writeback.sv
// APU write-back stage: stream -> FIFO -> activation SRAM A/B.
// One burst per iStart, consecutive wrapping addresses.
module apu_out_writeback
  import apu_wb_pkg::*;
#(
  parameter int P_BINDWIDTH  = WB_BINDWIDTH,
  parameter int P_ADDR_W     = WB_ADDR_W,
  parameter int P_FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   iStart,
  input  logic                   iAbort,
  input  logic [P_ADDR_W-1:0]    iBaseAddr,
  input  logic [P_ADDR_W:0]      iWordCount,
  input  logic                   iDstSelect,
  input  logic                   iValid,
  input  logic [P_BINDWIDTH-1:0] iData,
  output logic                   oReady,
  input  logic                   iStall,
  output logic                   oWeA,
  output logic                   oWeB,
  output logic                   oCe,
  output logic [P_ADDR_W-1:0]    oAddr,
  output logic [P_BINDWIDTH-1:0] oWriteData,
  output logic                   oBusy,
  output logic                   oDone
);

  wb_state_e             state_q, state_d;
  logic [P_ADDR_W-1:0]   base_q, base_d;
  logic [P_ADDR_W:0]     cnt_q, cnt_d;
  logic                  sel_q, sel_d;
  logic [P_ADDR_W:0]     acc_q, acc_d;
  logic [P_ADDR_W:0]     wr_q, wr_d;

  logic                   we_a_q, we_b_q, ce_q;
  logic [P_ADDR_W-1:0]    addr_q;
  logic [P_BINDWIDTH-1:0] wdata_q;

  logic                   run, drain, active;
  logic                   ready, push, pop, flush;
  logic                   fifo_full, fifo_empty;
  logic [P_BINDWIDTH-1:0] fifo_data;
  logic [P_ADDR_W-1:0]    wr_addr;

  assign run    = (state_q == S_RUN);
  assign drain  = (state_q == S_DRAIN);
  assign active = run || drain;
  assign ready  = run && !fifo_full && (acc_q < cnt_q);
  assign push   = iValid && ready && !iAbort;
  assign pop    = active && !fifo_empty && !iStall && !iAbort;
  assign flush  = iAbort && (state_q != S_IDLE);

  // Address wraps naturally by truncation to P_ADDR_W bits.
  assign wr_addr = base_q + wr_q[P_ADDR_W-1:0];

  wb_fifo #(
    .P_WIDTH (P_BINDWIDTH),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nRst    (nRst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (iData),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Burst FSM and accept/write counters.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    if (push) acc_d = acc_q + 1'b1;
    if (pop)  wr_d  = wr_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          base_d  = iBaseAddr;
          cnt_d   = iWordCount;
          sel_d   = iDstSelect;
          acc_d   = '0;
          wr_d    = '0;
          state_d = (iWordCount == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (acc_d == cnt_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_q == cnt_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        acc_d   = '0;
        wr_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      acc_d   = '0;
      wr_d    = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      acc_q   <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
    end
  end

  // Registered SRAM write pins; address/data hold when idle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      we_a_q  <= 1'b1;
      we_b_q  <= 1'b1;
      ce_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ce_q   <= !pop;
      we_a_q <= !(pop && !sel_q);
      we_b_q <= !(pop && sel_q);
      if (pop) begin
        addr_q  <= wr_addr;
        wdata_q <= fifo_data;
      end
    end
  end

  assign oReady     = ready;
  assign oWeA       = we_a_q;
  assign oWeB       = we_b_q;
  assign oCe        = ce_q;
  assign oAddr      = addr_q;
  assign oWriteData = wdata_q;
  assign oBusy      = active;
  assign oDone      = (state_q == S_DONE);

endmodule

// File: tb/tb_apu_out_writeback.sv
// Bench for apu_out_writeback: burst table + scoreboard,
// plus abort and mid-burst reset sequences.
module tb_apu_out_writeback;

  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          nRst;
  logic          iStart, iAbort, iDstSelect, iValid, iStall;
  logic [AW-1:0] iBaseAddr;
  logic [AW:0]   iWordCount;
  logic [DW-1:0] iData;
  logic          oReady, oWeA, oWeB, oCe, oBusy, oDone;
  logic [AW-1:0] oAddr;
  logic [DW-1:0] oWriteData;

  apu_out_writeback dut (
    .clk        (clk),
    .nRst       (nRst),
    .iStart     (iStart),
    .iAbort     (iAbort),
    .iBaseAddr  (iBaseAddr),
    .iWordCount (iWordCount),
    .iDstSelect (iDstSelect),
    .iValid     (iValid),
    .iData      (iData),
    .oReady     (oReady),
    .iStall     (iStall),
    .oWeA       (oWeA),
    .oWeB       (oWeB),
    .oCe        (oCe),
    .oAddr      (oAddr),
    .oWriteData (oWriteData),
    .oBusy      (oBusy),
    .oDone      (oDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          dst;
  } wr_t;

  typedef struct {
    logic [AW-1:0] base;
    int            cnt;
    logic          dst;
    int            stall_at;
    int            stall_len;
    int            restart_at;
    int            exp_done_rel;
    bit            chk_full;
  } vec_t;

  wr_t sb[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_start, nwr, ndone, done_cyc, last_wr_cyc;
  int next_idx, offer_left, burst_id;
  logic done_busy;
  logic [AW-1:0] cur_base;
  logic cur_dst;
  bit nxt_start, nxt_abort, nxt_stall, prev_stall;

  function automatic logic [DW-1:0] gen(int id, int i);
    return {16'hC0DE, id[7:0], 8'h3C, i[15:0] ^ 16'hA5A5, 16'(i * 7 + id)};
  endfunction

  task automatic check(string name, bit ok, logic [63:0] act,
                       logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Observe cycle outputs at negedge, then drive this cycle's inputs.
  task automatic step();
    wr_t e, n;
    @(negedge clk);
    cyc++;
    if (prev_stall) check("no_write_after_stall", oCe, oCe, 1);
    if (!oCe) begin
      nwr++;
      last_wr_cyc = cyc;
      if (sb.size() == 0) begin
        check("spurious_write", 0, oAddr, 0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", oAddr == e.addr, oAddr, e.addr);
        check("wr_data", oWriteData == e.data, oWriteData, e.data);
        check("wr_we", {oWeA, oWeB} == (e.dst ? 2'b10 : 2'b01),
              {oWeA, oWeB}, e.dst ? 2'b10 : 2'b01);
      end
    end else begin
      check("we_idle", oWeA && oWeB, {oWeA, oWeB}, 2'b11);
    end
    if (oDone) begin
      ndone++;
      done_cyc  = cyc;
      done_busy = oBusy;
    end
    iStart     = nxt_start;
    iAbort     = nxt_abort;
    iStall     = nxt_stall;
    prev_stall = nxt_stall;
    iValid     = (offer_left > 0);
    iData      = gen(burst_id, next_idx);
    if (iValid && oReady && !iAbort) begin
      n.addr = cur_base + next_idx[AW-1:0];
      n.data = iData;
      n.dst  = cur_dst;
      sb.push_back(n);
      next_idx++;
      offer_left--;
    end
  endtask

  task automatic begin_burst(logic [AW-1:0] base, int cnt, logic dst,
                             int id);
    sb.delete();
    next_idx    = 0;
    nwr         = 0;
    ndone       = 0;
    done_cyc    = -1;
    last_wr_cyc = -1;
    burst_id    = id;
    cur_base    = base;
    cur_dst     = dst;
    iBaseAddr   = base;
    iWordCount  = cnt[AW:0];
    iDstSelect  = dst;
    offer_left  = cnt;
    nxt_start   = 1'b1;
    step();
    n_start     = cyc;
    nxt_start   = 1'b0;
  endtask

  task automatic run_burst(vec_t v, int id);
    int rel;
    begin_burst(v.base, v.cnt, v.dst, id);
    for (int k = 0; k < 100 && ndone == 0; k++) begin
      rel       = cyc + 1 - n_start;
      nxt_stall = (v.stall_len > 0) && (rel >= v.stall_at) &&
                  (rel < v.stall_at + v.stall_len);
      nxt_start = (rel == v.restart_at);
      if (nxt_start) begin
        iBaseAddr  = v.base ^ 10'h155;
        iWordCount = 11'd2;
        iDstSelect = !v.dst;
      end
      step();
      if (cyc == n_start + 1) begin
        check("ready_after_start", oReady == (v.cnt > 0), oReady, v.cnt > 0);
        if (v.cnt > 0) check("busy_after_start", oBusy, oBusy, 1);
      end
      if (v.chk_full && cyc == n_start + v.stall_at + v.stall_len - 1) begin
        check("ready_low_when_full", !oReady, oReady, 0);
        check("buffered_words", sb.size() == 4, sb.size(), 4);
      end
    end
    nxt_stall = 1'b0;
    nxt_start = 1'b0;
    if (ndone == 0) begin
      check("done_timeout", 0, 0, 1);
    end else begin
      check("done_cycle", done_cyc - n_start == v.exp_done_rel,
            done_cyc - n_start, v.exp_done_rel);
      if (v.cnt > 0)
        check("done_after_last_wr", done_cyc == last_wr_cyc + 1,
              done_cyc - last_wr_cyc, 1);
      check("busy_at_done", !done_busy, done_busy, 0);
    end
    check("write_count", nwr == v.cnt, nwr, v.cnt);
    check("sb_drained", sb.size() == 0, sb.size(), 0);
    step();
    check("done_one_cycle", ndone == 1 && !oDone, ndone, 1);
    check("idle_after_done", !oBusy, oBusy, 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{10'h010, 4, 1'b0, 0, 0, -1, 7, 1'b0};
    vecs[1] = '{10'h3FE, 4, 1'b1, 0, 0, -1, 7, 1'b0};
    vecs[2] = '{10'h080, 8, 1'b0, 3, 6, -1, 17, 1'b1};
    vecs[3] = '{10'h200, 0, 1'b1, 0, 0, -1, 1, 1'b0};
    vecs[4] = '{10'h100, 4, 1'b0, 0, 0, 2, 7, 1'b0};
    vecs[5] = '{10'h3FC, 9, 1'b1, 5, 2, -1, 14, 1'b0};
    vecs[6] = '{10'h300, 3, 1'b1, 0, 0, -1, 6, 1'b0};

    nRst = 1'b0;
    iStart = 0; iAbort = 0; iStall = 0; iValid = 0; iDstSelect = 0;
    iBaseAddr = '0; iWordCount = '0; iData = '0;
    nxt_start = 0; nxt_abort = 0; nxt_stall = 0; prev_stall = 0;
    offer_left = 0; next_idx = 0; burst_id = 0; nwr = 0; ndone = 0;
    cur_base = '0; cur_dst = 0; done_busy = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", !oReady, oReady, 0);
    check("rst_we", oWeA && oWeB, {oWeA, oWeB}, 2'b11);
    check("rst_ce", oCe, oCe, 1);
    check("rst_addr_data", oAddr == 0 && oWriteData == 0, oAddr, 0);
    check("rst_busy_done", !oBusy && !oDone, {oBusy, oDone}, 0);
    nRst = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 6; i++) run_burst(vecs[i], i + 1);

    // Abort after three accepted words of a ten-word burst.
    begin_burst(10'h020, 10, 1'b0, 20);
    for (int k = 0; k < 20 && next_idx < 3; k++) step();
    nxt_abort  = 1'b1;
    offer_left = 0;
    step();
    nxt_abort = 1'b0;
    sb.delete();
    step();
    check("abort_ce_idle", oCe && oWeA && oWeB, {oCe, oWeA, oWeB}, 3'b111);
    check("abort_idle", !oBusy && !oReady, {oBusy, oReady}, 0);
    repeat (8) step();
    check("abort_writes", nwr == 2, nwr, 2);
    check("abort_no_done", ndone == 0, ndone, 0);
    run_burst(vecs[6], 21);

    // Asynchronous reset in the middle of a burst.
    begin_burst(10'h040, 8, 1'b1, 30);
    repeat (4) step();
    nRst = 1'b0;
    #1;
    check("midrst_ready", !oReady, oReady, 0);
    check("midrst_pins", oCe && oWeA && oWeB && oAddr == 0 &&
          oWriteData == 0, {oCe, oWeA, oWeB}, 3'b111);
    check("midrst_busy_done", !oBusy && !oDone, {oBusy, oDone}, 0);
    offer_left = 0;
    sb.delete();
    nwr = 0;
    repeat (2) step();
    nRst = 1'b1;
    repeat (8) step();
    check("midrst_no_writes", nwr == 0, nwr, 0);
    check("midrst_idle", !oBusy, oBusy, 0);
    vecs[0].base = 10'h005;
    vecs[0].cnt = 2;
    vecs[0].exp_done_rel = 5;
    run_burst(vecs[0], 31);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
